// File: rtl/write_fifo_if.sv
// Bundles the pixel-pair enqueue side and the memory write side of write_fifo.
// slave is the FIFO's view; master is the producer/memory environment's view.
interface write_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 5
);
  logic                     z_active;
  logic                     enqueue;
  logic [28:0]              color_address;
  logic [63:0]              color;
  logic [28:0]              z_address;
  logic [63:0]              z;
  logic [1:0]               pixel_active;
  logic [FIFO_DEPTH_LOG2:0] size;
  logic                     full;
  logic                     overflow;
  logic [28:0]              write_address;
  logic [63:0]              write_writedata;
  logic [7:0]               write_byteenable;
  logic                     write_write;
  logic                     write_waitrequest;
  logic                     busy;

  modport slave (
    input  z_active, enqueue, color_address, color, z_address, z, pixel_active,
           write_waitrequest,
    output size, full, overflow, write_address, write_writedata, write_byteenable,
           write_write, busy
  );

  modport master (
    output z_active, enqueue, color_address, color, z_address, z, pixel_active,
           write_waitrequest,
    input  size, full, overflow, write_address, write_writedata, write_byteenable,
           write_write, busy
  );
endinterface

// File: rtl/write_fifo.sv
// Queues color/Z pixel pairs and drains them as back-to-back 64-bit memory writes:
// a color write per entry, followed by a Z write when z_active was high at pop time.
module write_fifo #(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic         clock,
  input  logic         reset,
  write_fifo_if.slave  bus
);

  typedef struct packed {
    logic [28:0] color_address;
    logic [63:0] color;
    logic [28:0] z_address;
    logic [63:0] z;
    logic [1:0]  pixel_active;
  } entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, COLOR = 2'd1, ZWRITE = 2'd2} state_t;

  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_C  = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_LAST = FIFO_DEPTH_LOG2'(FIFO_DEPTH - 1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  function automatic logic [7:0] byte_en(input logic [1:0] pa);
    return {{4{pa[1]}}, {4{pa[0]}}};
  endfunction

  function automatic logic [FIFO_DEPTH_LOG2-1:0] ptr_inc(input logic [FIFO_DEPTH_LOG2-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  entry_t                     mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       overflow_flag;
  state_t                     state, state_next;
  entry_t                     hold, hold_next;
  logic                       hold_z, hold_z_next;
  logic [28:0]                addr_q, addr_next;
  logic [63:0]                data_q, data_next;
  logic [7:0]                 be_q, be_next;
  logic                       ww_q, ww_next;
  logic                       full_s, push, pop, accepted, complete;
  entry_t                     head;

  assign full_s   = (count == DEPTH_C);
  assign push     = bus.enqueue && !full_s;
  assign head     = mem[rd_ptr];
  assign accepted = ww_q && !bus.write_waitrequest;

  // Next-state and output selection; IDLE is treated like a just-completed entry.
  always_comb begin
    state_next  = state;
    hold_next   = hold;
    hold_z_next = hold_z;
    addr_next   = addr_q;
    data_next   = data_q;
    be_next     = be_q;
    ww_next     = ww_q;
    pop         = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE:   complete = 1'b1;
      COLOR: begin
        if (accepted && hold_z) begin
          state_next = ZWRITE;
          addr_next  = hold.z_address;
          data_next  = hold.z;
        end else begin
          complete = accepted;
        end
      end
      ZWRITE: complete = accepted;
      default: complete = 1'b1;
    endcase
    if (complete) begin
      state_next = IDLE;
      ww_next    = 1'b0;
      if (count != '0) begin
        pop         = 1'b1;
        hold_next   = head;
        hold_z_next = bus.z_active;
        // An all-disabled pair is consumed here without ever reaching the bus.
        if (head.pixel_active != 2'b00) begin
          state_next = COLOR;
          ww_next    = 1'b1;
          addr_next  = head.color_address;
          data_next  = head.color;
          be_next    = byte_en(head.pixel_active);
        end else begin
          state_next = IDLE;
        end
      end else begin
        pop = 1'b0;
      end
    end else begin
      pop = 1'b0;
    end
  end

  // State, pointers, occupancy, holding and bus output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
      hold          <= '0;
      hold_z        <= 1'b0;
      addr_q        <= 29'd0;
      data_q        <= 64'd0;
      be_q          <= 8'd0;
      ww_q          <= 1'b0;
    end else begin
      state  <= state_next;
      hold   <= hold_next;
      hold_z <= hold_z_next;
      addr_q <= addr_next;
      data_q <= data_next;
      be_q   <= be_next;
      ww_q   <= ww_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (bus.enqueue && full_s) overflow_flag <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{color_address: bus.color_address, color: bus.color,
                       z_address: bus.z_address, z: bus.z,
                       pixel_active: bus.pixel_active};
    end
  end

  assign bus.size             = count;
  assign bus.full             = full_s;
  assign bus.overflow         = overflow_flag;
  assign bus.write_address    = addr_q;
  assign bus.write_writedata  = data_q;
  assign bus.write_byteenable = be_q;
  assign bus.write_write      = ww_q;
  assign bus.busy             = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_write_fifo.sv
// Self-checking bench for write_fifo: directed table, multi-cycle corner sequences,
// and randomized bursts checked by an expected-write scoreboard.
module tb_write_fifo;
  localparam int DEPTH = 32;
  localparam int LOG2  = 5;

  logic clock = 1'b0;
  logic reset;
  write_fifo_if #(.FIFO_DEPTH_LOG2(LOG2)) bus ();
  write_fifo #(.FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;

  typedef struct { logic [28:0] addr; logic [63:0] data; logic [7:0] be; } wr_t;
  typedef struct {
    logic za; logic [1:0] pa; logic [28:0] ca; logic [63:0] c;
    logic [28:0] zad; logic [63:0] zz; logic [7:0] exp_be; int exp_writes;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  prev_out;
  logic prev_stall = 1'b0;
  logic rand_wait  = 1'b0;
  int   checks = 0, errors = 0, accepted_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte i belongs to the left pixel for i<4, to the right pixel otherwise.
  function automatic logic [7:0] be_of(input logic [1:0] pa);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i < 4) ? pa[0] : pa[1];
    return r;
  endfunction

  task automatic expect_entry(input logic za, input logic [1:0] pa, input logic [28:0] ca,
                              input logic [63:0] c, input logic [28:0] zad, input logic [63:0] zz);
    if (pa != 2'b00) begin
      exp_q.push_back('{addr: ca, data: c, be: be_of(pa)});
      if (za) exp_q.push_back('{addr: zad, data: zz, be: be_of(pa)});
    end
  endtask

  // Sampled at the falling edge: values here are what the next rising edge sees.
  task automatic monitor();
    wr_t cur;
    cur = '{addr: bus.write_address, data: bus.write_writedata, be: bus.write_byteenable};
    if (prev_stall) begin
      check("hold_ww", bus.write_write, 1'b1);
      check("hold_addr", cur.addr, prev_out.addr);
      check("hold_data", cur.data, prev_out.data);
      check("hold_be", cur.be, prev_out.be);
    end
    prev_stall = bus.write_write && bus.write_waitrequest && !reset;
    prev_out   = cur;
    if (!reset && bus.write_write && !bus.write_waitrequest) begin
      accepted_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h, required no write", cur.addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", cur.addr, e.addr);
        check("wr_data", cur.data, e.data);
        check("wr_be", cur.be, e.be);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (rand_wait) bus.write_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive_entry(input logic [1:0] pa, input logic [28:0] ca, input logic [63:0] c,
                             input logic [28:0] zad, input logic [63:0] zz);
    bus.enqueue       = 1'b1;
    bus.pixel_active  = pa;
    bus.color_address = ca;
    bus.color         = c;
    bus.z_address     = zad;
    bus.z             = zz;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_busy"}, bus.busy, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int base;
    vecs[0] = '{1'b0, 2'b11, 29'h0000100, 64'h1111_2222_3333_4444, 29'h1000100, 64'hAAAA_0000_BBBB_0000, 8'hFF, 1};
    vecs[1] = '{1'b1, 2'b01, 29'h0000200, 64'h5555_6666_7777_8888, 29'h1000200, 64'hCCCC_1111_DDDD_2222, 8'h0F, 2};
    vecs[2] = '{1'b0, 2'b00, 29'h0000300, 64'h0BAD_0BAD_0BAD_0BAD, 29'h1000300, 64'h0BAD_0000_0BAD_0000, 8'h00, 0};
    vecs[3] = '{1'b0, 2'b10, 29'h0000400, 64'h9999_AAAA_BBBB_CCCC, 29'h1000400, 64'h1234_5678_9ABC_DEF0, 8'hF0, 1};
    vecs[4] = '{1'b1, 2'b00, 29'h0000500, 64'hDEAD_BEEF_DEAD_BEEF, 29'h1000500, 64'hFEED_FACE_FEED_FACE, 8'h00, 0};
    vecs[5] = '{1'b1, 2'b10, 29'h0000600, 64'h0102_0304_0506_0708, 29'h1000600, 64'h1112_1314_1516_1718, 8'hF0, 2};
    vecs[6] = '{1'b1, 2'b11, 29'h1FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 29'h0000001, 64'h8000_0000_0000_0001, 8'hFF, 2};

    reset = 1'b1;
    bus.enqueue = 1'b0; bus.z_active = 1'b0; bus.pixel_active = 2'b00;
    bus.color_address = 29'd0; bus.color = 64'd0; bus.z_address = 29'd0; bus.z = 64'd0;
    bus.write_waitrequest = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    check("rst_size", bus.size, 0);
    check("rst_full", bus.full, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_ww", bus.write_write, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_addr", bus.write_address, 29'd0);
    check("rst_data", bus.write_writedata, 64'd0);
    check("rst_be", bus.write_byteenable, 8'd0);

    // Single entries: two-cycle latency, byte enables, write count, idle afterwards.
    for (int i = 0; i < 7; i++) begin
      bus.z_active = vecs[i].za;
      drive_entry(vecs[i].pa, vecs[i].ca, vecs[i].c, vecs[i].zad, vecs[i].zz);
      base = accepted_cnt;
      expect_entry(vecs[i].za, vecs[i].pa, vecs[i].ca, vecs[i].c, vecs[i].zad, vecs[i].zz);
      cycle();
      bus.enqueue = 1'b0;
      check("lat_ww_n", bus.write_write, 1'b0);
      cycle();
      check("lat_ww_n1", bus.write_write, vecs[i].exp_writes != 0);
      if (vecs[i].exp_writes != 0) begin
        check("first_addr", bus.write_address, vecs[i].ca);
        check("first_be", bus.write_byteenable, vecs[i].exp_be);
        cycle();
        // With no stall the Z write must follow the color write immediately.
        check("second_ww", bus.write_write, vecs[i].exp_writes == 2);
      end
      drain("vec", 20);
      check("vec_writes", accepted_cnt - base, vecs[i].exp_writes);
    end

    // Color write stalled for three cycles, accepted on the fourth.
    bus.z_active = 1'b0;
    bus.write_waitrequest = 1'b1;
    drive_entry(2'b11, 29'h0ABCDEF, 64'hCAFE_F00D_1234_5678, 29'h0000777, 64'd7);
    expect_entry(1'b0, 2'b11, 29'h0ABCDEF, 64'hCAFE_F00D_1234_5678, 29'h0000777, 64'd7);
    base = accepted_cnt;
    cycle();
    bus.enqueue = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("stall_ww", bus.write_write, 1'b1);
      check("stall_addr", bus.write_address, 29'h0ABCDEF);
      check("stall_data", bus.write_writedata, 64'hCAFE_F00D_1234_5678);
      check("stall_be", bus.write_byteenable, 8'hFF);
      if (i == 3) bus.write_waitrequest = 1'b0;
      cycle();
    end
    check("stall_ww_after", bus.write_write, 1'b0);
    check("stall_writes", accepted_cnt - base, 1);

    // Overflow: one entry sits stalled in the write stage, then 33 more arrive;
    // 32 fill the queue and the last is dropped.
    bus.write_waitrequest = 1'b1;
    drive_entry(2'b11, 29'h0000F00, 64'hF00, 29'd0, 64'd0);
    expect_entry(1'b0, 2'b11, 29'h0000F00, 64'hF00, 29'd0, 64'd0);
    base = accepted_cnt;
    cycle();
    bus.enqueue = 1'b0;
    cycle();
    check("ovf_pre_size", bus.size, 0);
    for (int i = 0; i < 33; i++) begin
      drive_entry(2'b11, 29'h0002000 + 29'(i), 64'h5A5A_0000_0000_0000 + 64'(i), 29'd0, 64'd0);
      if (i < 32) expect_entry(1'b0, 2'b11, 29'h0002000 + 29'(i), 64'h5A5A_0000_0000_0000 + 64'(i), 29'd0, 64'd0);
      if (i == 32) check("ovf_before_last", bus.overflow, 1'b0);
      cycle();
    end
    bus.enqueue = 1'b0;
    check("ovf_size", bus.size, 32);
    check("ovf_full", bus.full, 1'b1);
    check("ovf_flag", bus.overflow, 1'b1);
    bus.write_waitrequest = 1'b0;
    drain("ovf", 100);
    check("ovf_writes", accepted_cnt - base, 33);
    check("ovf_sticky", bus.overflow, 1'b1);

    // Reset during a Z write with five entries still queued.
    bus.z_active = 1'b1;
    bus.write_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_entry(2'b11, 29'h0003000 + 29'(i), 64'h3000 + 64'(i), 29'h0004000 + 29'(i), 64'h4000 + 64'(i));
      expect_entry(1'b1, 2'b11, 29'h0003000 + 29'(i), 64'h3000 + 64'(i), 29'h0004000 + 29'(i), 64'h4000 + 64'(i));
      cycle();
    end
    bus.enqueue = 1'b0;
    check("rz_size", bus.size, 5);
    bus.write_waitrequest = 1'b0;
    cycle();
    check("rz_in_zwrite_addr", bus.write_address, 29'h0004000);
    check("rz_in_zwrite_ww", bus.write_write, 1'b1);
    reset = 1'b1;
    drive_entry(2'b11, 29'h0005000, 64'h5000, 29'h0006000, 64'h6000);
    cycle();
    reset = 1'b0;
    bus.enqueue = 1'b0;
    exp_q.delete();
    check("rz_ww", bus.write_write, 1'b0);
    check("rz_size0", bus.size, 0);
    check("rz_busy", bus.busy, 1'b0);
    check("rz_overflow", bus.overflow, 1'b0);
    check("rz_addr", bus.write_address, 29'd0);
    check("rz_be", bus.write_byteenable, 8'd0);
    base = accepted_cnt;
    repeat (10) cycle();
    check("rz_no_writes", accepted_cnt - base, 0);

    // Randomized bursts with random stalls; z_active only changes while idle.
    rand_wait = 1'b1;
    for (int b = 0; b < 10; b++) begin
      int n, pushed;
      bus.z_active = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 20);
      pushed = 0;
      while (pushed < n) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [1:0]  pa;
          logic [28:0] ca, zad;
          logic [63:0] c, zz;
          pa  = 2'($urandom_range(0, 3));
          ca  = 29'($urandom);
          zad = 29'($urandom);
          c   = {$urandom, $urandom};
          zz  = {$urandom, $urandom};
          drive_entry(pa, ca, c, zad, zz);
          expect_entry(bus.z_active, pa, ca, c, zad, zz);
          pushed++;
        end else begin
          bus.enqueue = 1'b0;
        end
        cycle();
      end
      bus.enqueue = 1'b0;
      drain("rand", 400);
    end
    rand_wait = 1'b0;
    bus.write_waitrequest = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_fifo.md
WRITE_FIFO -- requirements
Module: write_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, meaning the number of queued pixel-pair entries.
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 5, meaning log2(FIFO_DEPTH).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port z_active, input, 1 bit: when high, each entry also writes Z.
REQ-006 SHALL have port enqueue, input, 1 bit: pushes one entry this cycle.
REQ-007 SHALL have port color_address, input, 29 bits: 64-bit word address of the color pair.
REQ-008 SHALL have port color, input, 64 bits: the color pair; [31:0] is the left pixel.
REQ-009 SHALL have port z_address, input, 29 bits: word address of the Z pair.
REQ-010 SHALL have port z, input, 64 bits: the Z pair; [31:0] is the left pixel.
REQ-011 SHALL have port pixel_active, input, 2 bits: per-pixel enable; bit 0 is the left pixel.
REQ-012 SHALL have port size, output, FIFO_DEPTH_LOG2+1 bits: the current entry count.
REQ-013 SHALL have port full, output, 1 bit: asserted when size == FIFO_DEPTH.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set when enqueue is dropped.
REQ-015 SHALL have port write_address, output, 29 bits: memory word address.
REQ-016 SHALL have port write_writedata, output, 64 bits: memory write data.
REQ-017 SHALL have port write_byteenable, output, 8 bits: memory byte enables.
REQ-018 SHALL have port write_write, output, 1 bit: memory write request.
REQ-019 SHALL have port write_waitrequest, input, 1 bit: memory stall.
REQ-020 SHALL have port busy, output, 1 bit: high when size != 0 or the state machine is not IDLE.

Function
REQ-021 SHALL accept an entry at a clock edge where enqueue=1 and full=0; an enqueue while full SHALL be dropped, SHALL set overflow, and SHALL leave the FIFO contents unchanged.
REQ-022 SHALL, on a simultaneous accepted enqueue and pop, leave size unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 SHALL implement states IDLE, COLOR, and ZWRITE.
REQ-024 SHALL, in IDLE with size != 0, pop the head entry into holding registers, latch z_active with it, and go to COLOR.
REQ-025 SHALL, for a popped entry with pixel_active == 2'b00, discard it without any write and stay in IDLE.
REQ-026 SHALL drive write_byteenable = {{4{pa[1]}},{4{pa[0]}}} from the held pixel_active for both the color and the Z write.
REQ-027 SHALL, in COLOR, drive write_write=1, write_address=color_address, and write_writedata=color.
REQ-028 SHALL, in ZWRITE, drive write_write=1, write_address=z_address, and write_writedata=z.
REQ-029 SHALL hold address, data, and byteenable stable while write_write=1 and write_waitrequest=1.
REQ-030 SHALL treat a write as accepted on an edge where write_write=1 and write_waitrequest=0.
REQ-031 SHALL, on acceptance in COLOR, go to ZWRITE if the held z_active=1; otherwise the entry is complete.
REQ-032 SHALL, on acceptance in ZWRITE, mark the entry complete.
REQ-033 SHALL, on entry completion with size != 0, pop the next entry in that same edge and go directly to COLOR, so writes stay back-to-back; a next entry with pixel_active=00 SHALL go to IDLE and be discarded there.
REQ-034 SHALL, on entry completion with size == 0, go to IDLE with write_write=0.
REQ-035 SHALL keep write_write=0 in IDLE.
REQ-036 SHALL have a latency of 2 cycles: enqueue at edge N into an empty idle block gives write_write=1 in the cycle after edge N+1.
REQ-037 SHALL give peak throughput of one write per cycle: with z_active=0, one entry per cycle; with z_active=1, one entry per two cycles.
REQ-038 SHALL ignore changes to z_active for an entry already popped.

Reset
REQ-039 SHALL, on reset=1 at a clock edge, set state=IDLE, empty the FIFO, and set size=0, full=0, overflow=0, write_write=0, and busy=0.
REQ-040 SHALL, on reset=1 at a clock edge, set write_address, write_writedata, and write_byteenable to 0.
REQ-041 SHALL, on reset asserted mid-write, drop the write (write_write=0 after that edge) and lose all queued entries.
REQ-042 SHALL ignore enqueue on an edge where reset=1.

Verification
REQ-043 SHALL verify single entry, z_active=0, pa=11, waitrequest=0: exactly one write appears 2 cycles after enqueue, with addr=color_address and byteenable=FF; then busy=0.
REQ-044 SHALL verify single entry, z_active=1, pa=01: a color write then a Z write in consecutive cycles, both with byteenable=0F.
REQ-045 SHALL verify waitrequest held high 3 cycles during COLOR: outputs are held stable 4 cycles, and exactly one color write is accepted.
REQ-046 SHALL verify 33 back-to-back enqueues with waitrequest=1: size=32, full=1, overflow=1, and the 33rd entry is never written; on release, 32 writes occur in order.
REQ-047 SHALL verify entries with pa=00 interleaved with pa=10: no write for the pa=00 entries, and byteenable=F0 for the others.
REQ-048 SHALL verify reset asserted during ZWRITE with 5 queued entries: write_write=0 and size=0 the next cycle, and no further writes occur.
